// File: rtl/vram_fill_engine_if.sv
// Bus bundle between the fill engine, the image ROM read port and the
// VRAM write port. blank arrives with the VRAM port because it
// decides when that port may be written.
interface vram_fill_engine_if #(
    parameter int DW      = 9,
    parameter int ROM_AW  = 12,
    parameter int VRAM_AW = 11
);
    logic [ROM_AW-1:0]  rom_addr;
    logic [DW-1:0]      rom_data;
    logic [VRAM_AW-1:0] vram_addr;
    logic [DW-1:0]      vram_wdata;
    logic               vram_wre;
    logic               blank;

    modport master (
        output rom_addr, vram_addr, vram_wdata, vram_wre,
        input  rom_data, blank
    );

    modport slave (
        input  rom_addr, vram_addr, vram_wdata, vram_wre,
        output rom_data, blank
    );
endinterface

// File: rtl/vram_fill_engine.sv
// Streams DEPTH words from a synchronous-read image ROM into the LCD
// video RAM. Writes happen only during blanking, at one word per clock,
// and stall without loss when blank drops.
//
// state | meaning
// IDLE  | waiting for start
// PRIME | one cycle presenting word 0 to the ROM
// WRITE | writing one word on every cycle where blank=1
module vram_fill_engine #(
    parameter int DW       = 9,
    parameter int ROM_AW   = 12,
    parameter int VRAM_AW  = 11,
    parameter int DEPTH    = 2048,
    parameter int ROM_BASE = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  loop_en,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic [7:0]            pass_cnt,
    vram_fill_engine_if.master    bus
);
    localparam int          IW         = $clog2(DEPTH) + 1;
    localparam logic [31:0] ROM_BASE_U = 32'(ROM_BASE);

    typedef enum logic [1:0] {IDLE, PRIME, WRITE} state_t;

    state_t        state, state_nxt;
    logic [IW-1:0] idx, idx_nxt;
    logic [7:0]    pass_nxt;
    logic          done_nxt;
    logic          fire;
    logic          last;

    // Next-state and datapath decisions; abort overrides everything.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        pass_nxt  = pass_cnt;
        done_nxt  = 1'b0;
        fire      = (state == WRITE) && bus.blank && !abort;
        last      = (idx == IW'(DEPTH - 1));
        if (abort) begin
            state_nxt = IDLE;
            idx_nxt   = '0;
        end else begin
            case (state)
                IDLE:  if (start) state_nxt = PRIME;
                PRIME: state_nxt = WRITE;
                WRITE: begin
                    if (fire) begin
                        if (last) begin
                            idx_nxt   = '0;
                            done_nxt  = 1'b1;
                            pass_nxt  = pass_cnt + 8'd1;
                            state_nxt = loop_en ? PRIME : IDLE;
                        end else begin
                            idx_nxt = idx + IW'(1);
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Look one word ahead on a write so the ROM output tracks idx after the edge.
    always_comb begin
        bus.rom_addr   = ROM_AW'(ROM_BASE_U + 32'(idx) + 32'(fire));
        bus.vram_addr  = VRAM_AW'(idx);
        bus.vram_wdata = bus.rom_data;
        bus.vram_wre   = fire;
        busy           = (state != IDLE);
    end

    // State, word index, done pulse and pass counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            idx      <= '0;
            done     <= 1'b0;
            pass_cnt <= 8'd0;
        end else begin
            state    <= state_nxt;
            idx      <= idx_nxt;
            done     <= done_nxt;
            pass_cnt <= pass_nxt;
        end
    end
endmodule

// File: tb/tb_vram_fill_engine.sv
// Directed bench for vram_fill_engine with DEPTH=8 and ROM[a]=a+0x10.
module tb_vram_fill_engine;
    localparam int DW = 9, ROM_AW = 12, VRAM_AW = 11, DEPTH = 8;

    logic       clk, rst, start, loop_en, abort, blank;
    logic       busy, done;
    logic [7:0] pass_cnt;
    logic [DW-1:0] rom_q = '0;

    int n_tests = 0, n_fail = 0;
    int cyc_n = 0;

    // abstract model: phase 0 idle, 1 priming, 2 writing; m_pos = next word
    int m_phase, m_pos, m_passes, m_done;

    // monitor bookkeeping
    int wr_cnt, done_cnt, first_wr_cyc, first_wr_addr, done_cyc;
    int wr_per_addr [DEPTH];
    int vram_mem [DEPTH];
    int done_pc [8];
    int start_cyc;
    logic [31:0] pat;

    vram_fill_engine_if #(.DW(DW), .ROM_AW(ROM_AW), .VRAM_AW(VRAM_AW)) bus ();

    vram_fill_engine #(.DW(DW), .ROM_AW(ROM_AW), .VRAM_AW(VRAM_AW),
                       .DEPTH(DEPTH), .ROM_BASE(0)) dut (
        .clk(clk), .rst(rst), .start(start), .loop_en(loop_en), .abort(abort),
        .busy(busy), .done(done), .pass_cnt(pass_cnt), .bus(bus)
    );

    assign bus.rom_data = rom_q;
    assign bus.blank    = blank;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // synchronous image ROM: word at address a is a+0x10
    always @(posedge clk) rom_q <= DW'(bus.rom_addr + 12'h010);

    always @(posedge clk) cyc_n++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    // model of the fill sequence, advanced on each clock edge
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_phase = 0; m_pos = 0; m_passes = 0; m_done = 0;
        end else begin
            m_done = 0;
            if (abort) begin
                m_phase = 0; m_pos = 0;
            end else if (m_phase == 0) begin
                if (start) m_phase = 1;
            end else if (m_phase == 1) begin
                m_phase = 2;
            end else if (blank) begin
                if (m_pos == DEPTH - 1) begin
                    m_pos = 0;
                    m_passes = (m_passes + 1) % 256;
                    m_done = 1;
                    m_phase = loop_en ? 1 : 0;
                end else begin
                    m_pos = m_pos + 1;
                end
            end
        end
    end

    // per-cycle comparison against the model, plus write/done bookkeeping
    always @(negedge clk) begin
        int exp_wre;
        exp_wre = (m_phase == 2 && blank && !abort) ? 1 : 0;
        check("busy", 32'(busy), (m_phase != 0) ? 1 : 0);
        check("done", 32'(done), m_done);
        check("pass_cnt", 32'(pass_cnt), m_passes);
        check("vram_wre", 32'(bus.vram_wre), exp_wre);
        check("vram_addr", 32'(bus.vram_addr), m_pos);
        check("rom_addr", 32'(bus.rom_addr), m_pos + exp_wre);
        if (exp_wre != 0) check("vram_wdata", 32'(bus.vram_wdata), (m_pos + 16) & 32'h1ff);
        if (bus.vram_wre === 1'b1) begin
            if (first_wr_cyc < 0) begin
                first_wr_cyc  = cyc_n;
                first_wr_addr = int'(bus.vram_addr);
            end
            wr_cnt++;
            if (bus.vram_addr < DEPTH) begin
                wr_per_addr[bus.vram_addr] = wr_per_addr[bus.vram_addr] + 1;
                vram_mem[bus.vram_addr]    = int'(bus.vram_wdata);
            end
        end
        if (done === 1'b1) begin
            if (done_cnt < 8) done_pc[done_cnt] = int'(pass_cnt);
            done_cnt++;
            done_cyc = cyc_n;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        wr_cnt = 0; done_cnt = 0; first_wr_cyc = -1; first_wr_addr = -1; done_cyc = -1;
        for (int i = 0; i < DEPTH; i++) begin
            wr_per_addr[i] = 0;
            vram_mem[i] = -1;
        end
        for (int i = 0; i < 8; i++) done_pc[i] = -1;
    endtask

    task automatic check_image(input string tag);
        for (int a = 0; a < DEPTH; a++) begin
            check({tag, "_writes_per_addr"}, wr_per_addr[a], 1);
            check({tag, "_vram_word"}, vram_mem[a], 16 + a);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; start = 1'b0; loop_en = 1'b0; abort = 1'b0; blank = 1'b0;
        pat = 32'b1001_0110_1100_0101_1011_0011_1010_0110;
        clear_mon();
        cyc(3);
        check("reset_busy", 32'(busy), 0);
        check("reset_pass_cnt", 32'(pass_cnt), 0);
        check("reset_rom_addr", 32'(bus.rom_addr), 0);
        rst = 1'b1;
        cyc(2);

        // single pass, blank held high
        clear_mon();
        blank = 1'b1;
        start = 1'b1; start_cyc = cyc_n;
        cyc(1); start = 1'b0;
        cyc(12);
        check("p1_write_count", wr_cnt, 8);
        check("p1_done_count", done_cnt, 1);
        check("p1_first_write_latency", first_wr_cyc - start_cyc, 2);
        check("p1_done_latency", done_cyc - start_cyc, 10);
        check("p1_pass_cnt", 32'(pass_cnt), 1);
        check("p1_busy", 32'(busy), 0);
        check_image("p1");

        // single pass with blank toggling
        clear_mon();
        start = 1'b1;
        cyc(1); start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            blank = pat[i % 32];
            cyc(1);
        end
        blank = 1'b1;
        cyc(12);
        check("stall_write_count", wr_cnt, 8);
        check("stall_done_count", done_cnt, 1);
        check("stall_pass_cnt", 32'(pass_cnt), 2);
        check_image("stall");

        // three looping passes from a fresh reset, with a stray start mid-pass
        rst = 1'b0; cyc(1); rst = 1'b1;
        clear_mon();
        loop_en = 1'b1; blank = 1'b1;
        start = 1'b1;
        cyc(1); start = 1'b0;
        cyc(12);
        start = 1'b1;
        cyc(1); start = 1'b0;
        cyc(7);
        loop_en = 1'b0;
        cyc(12);
        check("loop_done_count", done_cnt, 3);
        check("loop_pass_at_done1", done_pc[0], 1);
        check("loop_pass_at_done2", done_pc[1], 2);
        check("loop_pass_at_done3", done_pc[2], 3);
        check("loop_write_count", wr_cnt, 24);
        check("loop_busy_end", 32'(busy), 0);

        // abort after four writes, start in the same cycle
        clear_mon();
        start = 1'b1;
        cyc(1); start = 1'b0;
        cyc(5);
        abort = 1'b1; start = 1'b1;
        #1;
        check("abort_wre", 32'(bus.vram_wre), 0);
        cyc(1);
        abort = 1'b0; start = 1'b0;
        check("abort_busy", 32'(busy), 0);
        check("abort_pass_cnt", 32'(pass_cnt), 3);
        check("abort_write_count", wr_cnt, 4);
        cyc(2);
        check("abort_no_done", done_cnt, 0);
        clear_mon();
        start = 1'b1;
        cyc(1); start = 1'b0;
        cyc(12);
        check("restart_first_addr", first_wr_addr, 0);
        check("restart_write_count", wr_cnt, 8);
        check("restart_pass_cnt", 32'(pass_cnt), 4);
        check_image("restart");

        // asynchronous reset in the middle of a pass
        clear_mon();
        start = 1'b1;
        cyc(1); start = 1'b0;
        cyc(4);
        #1;
        rst = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 0);
        check("arst_wre", 32'(bus.vram_wre), 0);
        check("arst_vram_addr", 32'(bus.vram_addr), 0);
        check("arst_rom_addr", 32'(bus.rom_addr), 0);
        check("arst_pass_cnt", 32'(pass_cnt), 0);
        check("arst_done", 32'(done), 0);
        cyc(2);
        rst = 1'b1;
        cyc(3);
        check("arst_no_done", done_cnt, 0);
        check("arst_pass_cnt_after", 32'(pass_cnt), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
